// File: rtl/line_buffer_fifo.sv
// Line-buffered byte FIFO: collects received bytes and releases them to the transmitter a line at a time.
// Define LINEBUF_TIMEOUT_EN to also flush a partial line after TIMEOUT idle cycles.
module line_buffer_fifo #(
    parameter int unsigned     DW      = 8,
    parameter int unsigned     LGFLEN  = 8,
    parameter int unsigned     MAXLINE = 80,
    parameter logic [DW-1:0]   TERM_A  = 8'h0a,
    parameter logic [DW-1:0]   TERM_B  = 8'h0d,
    parameter logic [23:0]     TIMEOUT = 24'd1000000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_stb,
    input  logic [DW-1:0]     i_rx_data,
    output logic              o_tx_stb,
    output logic [DW-1:0]     o_tx_data,
    input  logic              i_tx_busy,
    input  logic              i_clr_ovfl,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);

    localparam int unsigned     Depth    = 1 << LGFLEN;
    localparam logic [LGFLEN:0] PtrOne   = {{LGFLEN{1'b0}}, 1'b1};
    localparam logic [LGFLEN:0] FullFill = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [LGFLEN:0] MaxLineW = (LGFLEN + 1)'(MAXLINE);

    typedef enum logic {StIdle, StDrain} state_e;

    logic [DW-1:0]   mem [Depth];
    logic [LGFLEN:0] rd_q, wr_q, lineend_q, fill;
    state_e          state_q;
    logic            ready_q;
    logic            wr_en, drop, is_term, accept, maxline_hit, timeout_hit;

    assign fill        = wr_q - rd_q;
    assign o_fill      = fill;
    assign o_empty     = (fill == '0);
    assign o_full      = (fill == FullFill);
    assign wr_en       = i_rx_stb && !o_full;
    assign drop        = i_rx_stb && o_full;
    assign is_term     = (i_rx_data == TERM_A) || (i_rx_data == TERM_B);
    assign accept      = o_tx_stb && !i_tx_busy;
    assign maxline_hit = (state_q == StIdle) && (fill >= MaxLineW);

`ifdef LINEBUF_TIMEOUT_EN
    logic [23:0] idle_cnt_q;

    assign timeout_hit = (state_q == StIdle) && !o_empty && !i_rx_stb &&
                         (idle_cnt_q == TIMEOUT - 24'd1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idle_cnt_q <= '0;
        end else if (state_q != StIdle || o_empty || i_rx_stb || timeout_hit) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 24'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset && wr_en) begin
            mem[wr_q[LGFLEN-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_q       <= '0;
            wr_q       <= '0;
            lineend_q  <= '0;
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            o_tx_stb   <= 1'b0;
            o_tx_data  <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_q <= wr_q + PtrOne;
            end

            // ready_q delays the first presentation by one cycle after entering DRAIN
            ready_q <= (state_q == StDrain);
            if (accept) begin
                rd_q     <= rd_q + PtrOne;
                o_tx_stb <= 1'b0;
            end else if (!o_tx_stb && state_q == StDrain && ready_q && rd_q != lineend_q) begin
                o_tx_stb  <= 1'b1;
                o_tx_data <= mem[rd_q[LGFLEN-1:0]];
            end

            if (wr_en && is_term) begin
                lineend_q <= wr_q + PtrOne;
                state_q   <= StDrain;
            end else if (drop && is_term) begin
                lineend_q <= wr_q;
                state_q   <= StDrain;
            end else if (maxline_hit || timeout_hit) begin
                lineend_q <= wr_q;
                state_q   <= StDrain;
            end else if (state_q == StDrain && !o_tx_stb && rd_q == lineend_q) begin
                state_q <= StIdle;
            end

            // a drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovfl) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule
